uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Serial UART receiver with a receive FIFO; the downstream partner of uart_tx_fifo.
//  - Samples the asynchronous rx line and deframes 8N1, 8E1 or 8O1 characters.
//  - Pushes each good byte into a 2^W-deep first-word-fall-through FIFO that the host pops with rd_i.
//  - Flags parity, framing and overrun errors as sticky bits.
// PARAMETERS
//  P      0  parity mode: 0 = none, 1 = even, 2 = odd (same encoding as uart_tx_fifo)
//  W      2  FIFO address width; depth = 2**W
//  TIMER  5  clocks per bit (baud divisor), min 4; identical value to the transmitter
// PORTS
//  clk         in   1    system clock, rising edge
//  reset       in   1    synchronous, active-high reset
//  rx          in   1    serial input, idle high, asynchronous to clk
//  rd_i        in   1    pop head of FIFO (ignored when empty)
//  clr_err     in   1    clears parity_err/frame_err/overrun
//  r_data      out  8    FIFO head, valid while empty=0
//  empty       out  1    FIFO empty
//  full        out  1    FIFO holds 2**W bytes
//  count       out  W+1  bytes held
//  parity_err  out  1    sticky: a frame had bad parity
//  frame_err   out  1    sticky: a stop bit was sampled low
//  overrun     out  1    sticky: a good byte arrived while full and was dropped
// BEHAVIOUR
//  Reset values (sync, all): state=IDLE, FIFO empty (empty=1, full=0, count=0, r_data=0), all error flags 0.
//  Reset mid-frame aborts the frame; no partial byte is written.
//  Input synchroniser: rx passes two flops (rx_s); all decisions use rx_s; 2-cycle input latency.
//  Bit timer: counts 0..TIMER-1, width $clog2(TIMER); reloads to 0 on each bit boundary.
//  FSM:
//   IDLE   - rx_s falling (1->0) -> START, timer=0.
//   START  - at timer=TIMER/2 (integer div) sample rx_s.
//            If 1: glitch, -> IDLE.
//            If 0: -> DATA, bit index=0; sample point is now mid-bit.
//   DATA   - every TIMER cycles sample one bit into shift reg, LSB first.
//            After bit 7: -> PARITY if P!=0, else -> STOP.
//   PARITY - one sample after TIMER cycles; expected = ^data (P=1) or ~^data (P=2); mismatch latches perr_q.
//   STOP   - sample after TIMER cycles:
//             - rx_s=1 and perr_q=0 -> push byte, -> IDLE.
//             - rx_s=1 and perr_q=1 -> drop byte, parity_err<=1, -> IDLE.
//             - rx_s=0 -> drop byte, frame_err<=1, -> BREAK.
//   BREAK  - wait for rx_s=1, then -> IDLE; a held-low line yields exactly one frame error.
//  Push timing: byte written on the stop-sample edge; empty falls and r_data is valid the next cycle.
//  FIFO: first-word fall-through; r_data = mem[rd_ptr] combinationally from registered pointers.
//   - Pointers wrap modulo 2**W; count tracks occupancy.
//   - rd_i with empty=1: no effect.
//   - Push while full and rd_i=0: byte dropped, overrun<=1.
//   - Push and rd_i in the same cycle when full: both accepted, count unchanged, no overrun.
//   - Push and rd_i in the same cycle when empty: push only; the byte appears next cycle.
//  Error flags: set wins over clr_err in the same cycle; they do not affect FIFO contents.
// STRUCTURE
//  uart_pkg: shared parity mode constants (PAR_NONE/EVEN/ODD) and the rx FSM state encoding.
//   - The same parity constants are used by uart_tx_fifo.
//  Sub-module: uart_sync_fifo #(DW=8, W) holding the mem, pointers, count, empty, full.
//   - uart_sync_fifo is reusable by the tx side.
//  The top level holds the synchroniser, bit timer, FSM, shift register and error flags.
// TESTING (bench uses TIMER=5, W=2; bit period 5 clk)
//  1 P=0, drive frame 0x05 (start, 10100000, stop) -> one cycle after stop sample: empty=0, r_data=0x05, count=1.
//    Then rd_i=1 for one clock -> empty=1.
//  2 Loopback from uart_tx_fifo (same P/TIMER); send 0x05,0x06,0x07,0x0f -> read back in order.
//    No error flags set.
//  3 Overrun: 5 frames 0x01..0x05 with no reads -> full=1, count=4, FIFO holds 0x01..0x04, overrun=1.
//    clr_err then clears overrun.
//  4 P=1, frame 0xAA with parity bit 1 (wrong) -> parity_err=1, empty stays 1.
//    Next frame 0xAA with parity 0 -> stored.
//  5 Glitch: rx low for 2 clocks then high -> FSM back to IDLE, no push.
//    Stop bit low (break of 30 clocks) -> frame_err=1 once, no push.
//  6 Reset asserted during DATA bit 3 -> all outputs at reset values next cycle.
//    The following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: the parity mode encoding common to the rx and tx
// sides, the receiver FSM state encoding, and the expected-parity helper.
package uart_pkg;

  // Parity modes. The transmitter uses the same values, so a P setting means
  // the same thing on both ends of the link.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Receiver deframing states.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  // Returns the parity bit a correct frame carries for this data byte.
  // Even parity makes the total count of ones even; odd makes it odd.
  function automatic logic expected_parity(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO, 2**W entries of DW bits.
// The head word is presented combinationally from the registered read
// pointer and reads as zero while the FIFO is empty.
module uart_sync_fifo #(
  parameter int DW = 8,
  parameter int W  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [W:0]    count_o
);

  localparam int DEPTH = 2 ** W;

  logic [DW-1:0] mem_q [DEPTH];
  logic [W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [W:0]    count_q,  count_d;
  logic          do_rd;
  logic          do_wr;

  // A pop on an empty FIFO is ignored. A push is accepted when there is room,
  // or when a pop in the same cycle frees the slot (full + push + pop).
  // An empty FIFO with push + pop only pushes; the byte shows up next cycle.
  assign do_rd = rd_i & ~empty_o;
  assign do_wr = wr_i & (~full_o | do_rd);

  // Occupancy never exceeds 2**W, so the top count bit alone means full.
  assign empty_o = (count_q == '0);
  assign full_o  = count_q[W];
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + W'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (W+1)'(1);
      2'b01:   count_d = count_q - (W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1 / 8E1 / 8O1) feeding a first-word-fall-through FIFO.
// Holds the input synchroniser, bit timer, deframing FSM, shift register and
// sticky error flags; storage lives in uart_sync_fifo.
import uart_pkg::*;

module uart_rx_fifo #(
  parameter int P     = 0,
  parameter int W     = 2,
  parameter int TIMER = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  input  logic         rd_i,
  input  logic         clr_err,
  output logic [7:0]   r_data,
  output logic         empty,
  output logic         full,
  output logic [W:0]   count,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun
);

  localparam int TW = $clog2(TIMER);
  localparam logic [TW-1:0] T_LAST = TW'(TIMER - 1);
  localparam logic [TW-1:0] T_HALF = TW'(TIMER / 2);

  logic          rx_meta_q;
  logic          rx_s_q;
  logic          rx_prev_q;
  rx_state_e     state_q,  state_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [2:0]    bit_q,    bit_d;
  logic [7:0]    shift_q,  shift_d;
  logic          perr_q,   perr_d;
  logic          parity_err_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          tick;
  logic          push;
  logic          set_perr;
  logic          set_ferr;
  logic          set_ovr;

  // Two-flop synchroniser plus one delayed copy for start-edge detection.
  // Idle level is high so a reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // After the mid-start-bit alignment, every TIMER clocks lands mid-bit.
  assign tick = (timer_q == T_LAST);

  // Deframing FSM: next state, bit timer, shift register and error events.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    push     = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        timer_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = RX_START;
          perr_d  = 1'b0;
        end
      end
      RX_START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          if (rx_s_q) begin
            state_d = RX_IDLE;          // start bit did not hold: glitch
          end else begin
            state_d = RX_DATA;
            bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          timer_d = '0;
          shift_d = {rx_s_q, shift_q[7:1]};   // LSB arrives first
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (P != PAR_NONE) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (tick) begin
          timer_d = '0;
          if (rx_s_q != expected_parity(shift_q, P)) perr_d = 1'b1;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick) begin
          timer_d = '0;
          if (rx_s_q) begin
            if (perr_q) set_perr = 1'b1;
            else        push     = 1'b1;
            state_d = RX_IDLE;
          end else begin
            set_ferr = 1'b1;
            state_d  = RX_BREAK;        // hold here so a long low is one error
          end
        end
      end
      RX_BREAK: begin
        timer_d = '0;
        if (rx_s_q) state_d = RX_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  // Deframing state registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
    end
  end

  // A good byte is lost only when the FIFO is full and nothing is popped.
  assign set_ovr = push & full & ~rd_i;

  // Sticky error flags; a new error in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      parity_err_q <= set_perr | (parity_err_q & ~clr_err);
      frame_err_q  <= set_ferr | (frame_err_q  & ~clr_err);
      overrun_q    <= set_ovr  | (overrun_q    & ~clr_err);
    end
  end

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

  uart_sync_fifo #(
    .DW (8),
    .W  (W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (push),
    .wdata_i (shift_q),
    .rd_i    (rd_i),
    .rdata_o (r_data),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (no / even / odd parity) driven by
// a bit-level line driver, checked against a queue-based frame model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int TIMER = 5;
  localparam int W     = 2;
  localparam int DEPTH = 4;
  localparam int NI    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_v  [NI];
  logic       rd_v  [NI];
  logic       clr_v [NI];
  logic [7:0] r_data_w [NI];
  logic       empty_w  [NI];
  logic       full_w   [NI];
  logic [W:0] count_w  [NI];
  logic       perr_w   [NI];
  logic       ferr_w   [NI];
  logic       ovr_w    [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      uart_rx_fifo #(.P(gi), .W(W), .TIMER(TIMER)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_v[gi]),
        .rd_i       (rd_v[gi]),
        .clr_err    (clr_v[gi]),
        .r_data     (r_data_w[gi]),
        .empty      (empty_w[gi]),
        .full       (full_w[gi]),
        .count      (count_w[gi]),
        .parity_err (perr_w[gi]),
        .frame_err  (ferr_w[gi]),
        .overrun    (ovr_w[gi])
      );
    end
  endgenerate

  // Reference model: what each receiver should hold, frame by frame.
  logic [7:0] mq [NI][$];
  bit         m_perr [NI];
  bit         m_ferr [NI];
  bit         m_ovr  [NI];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input int sel, input string tag);
    int n;
    n = mq[sel].size();
    check_eq($sformatf("%s.u%0d.count", tag, sel), 32'(count_w[sel]), 32'(n));
    check_eq($sformatf("%s.u%0d.empty", tag, sel), 32'(empty_w[sel]), 32'(n == 0));
    check_eq($sformatf("%s.u%0d.full",  tag, sel), 32'(full_w[sel]),  32'(n == DEPTH));
    check_eq($sformatf("%s.u%0d.rdata", tag, sel), 32'(r_data_w[sel]), (n > 0) ? 32'(mq[sel][0]) : 32'd0);
    check_eq($sformatf("%s.u%0d.perr",  tag, sel), 32'(perr_w[sel]), 32'(m_perr[sel]));
    check_eq($sformatf("%s.u%0d.ferr",  tag, sel), 32'(ferr_w[sel]), 32'(m_ferr[sel]));
    check_eq($sformatf("%s.u%0d.ovr",   tag, sel), 32'(ovr_w[sel]),  32'(m_ovr[sel]));
  endtask

  // Clock edges from a #1-after-edge point back to a #1-after-edge point.
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_bit(input int sel, input logic b, input int n);
    rx_v[sel] = b;
    wait_clk(n);
  endtask

  // Edge (counted from the edge before the start bit is driven) on which the
  // stop bit is sampled: 2 sync flops, 1 edge to enter START, half a bit to
  // mid-start, then one bit period per data/parity/stop bit.
  function automatic int push_off(input int sel);
    return 3 + TIMER / 2 + 1 + TIMER * ((sel != 0) ? 10 : 9);
  endfunction

  function automatic logic par_bit(input int sel, input logic [7:0] d);
    return (sel == PAR_ODD) ? ~^d : ^d;
  endfunction

  // Drives one whole frame plus three idle bit times; updates no model state.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit badpar, input bit brk);
    line_bit(sel, 1'b0, TIMER);
    for (int i = 0; i < 8; i++) line_bit(sel, d[i], TIMER);
    if (sel != 0) line_bit(sel, par_bit(sel, d) ^ badpar, TIMER);
    if (brk) line_bit(sel, 1'b0, 30);
    line_bit(sel, 1'b1, 3 * TIMER);
  endtask

  // What the receiver should do with a completed frame, given the FIFO state.
  task automatic model_frame(input int sel, input logic [7:0] d, input bit badpar, input bit brk);
    if (brk)                         m_ferr[sel] = 1'b1;
    else if (badpar)                 m_perr[sel] = 1'b1;
    else if (mq[sel].size() == DEPTH) m_ovr[sel] = 1'b1;
    else                             mq[sel].push_back(d);
  endtask

  task automatic frame(input int sel, input logic [7:0] d, input bit badpar, input bit brk, input string tag);
    send_frame(sel, d, badpar, brk);
    model_frame(sel, d, badpar, brk);
    $display("frame u%0d data=%02h badpar=%0d brk=%0d count=%0d", sel, d, badpar, brk, count_w[sel]);
    check_state(sel, tag);
  endtask

  task automatic pop(input int sel, input string tag);
    rd_v[sel] = 1'b1;
    wait_clk(1);
    rd_v[sel] = 1'b0;
    if (mq[sel].size() > 0) void'(mq[sel].pop_front());
    $display("pop   u%0d count=%0d", sel, count_w[sel]);
    check_state(sel, tag);
  endtask

  task automatic clear_err(input int sel);
    clr_v[sel] = 1'b1;
    wait_clk(1);
    clr_v[sel] = 1'b0;
    m_perr[sel] = 1'b0;
    m_ferr[sel] = 1'b0;
    m_ovr[sel]  = 1'b0;
    check_state(sel, "clr");
  endtask

  task automatic model_reset();
    for (int s = 0; s < NI; s++) begin
      mq[s].delete();
      m_perr[s] = 1'b0;
      m_ferr[s] = 1'b0;
      m_ovr[s]  = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] rb;
    int         sel;
    int         kind;
    logic [7:0] d5a;

    for (int s = 0; s < NI; s++) begin
      rx_v[s] = 1'b1; rd_v[s] = 1'b0; clr_v[s] = 1'b0;
    end
    model_reset();
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    for (int s = 0; s < NI; s++) check_state(s, "reset");
    wait_clk(2);

    // 1: single byte, push latency and pop.
    fork
      send_frame(0, 8'h05, 1'b0, 1'b0);
      begin
        wait_clk(push_off(0) - 1);
        check_eq("t1.empty_before_push", 32'(empty_w[0]), 32'd1);
        wait_clk(1);
        check_eq("t1.empty_after_push", 32'(empty_w[0]), 32'd0);
        check_eq("t1.rdata_after_push", 32'(r_data_w[0]), 32'h05);
        check_eq("t1.count_after_push", 32'(count_w[0]), 32'd1);
      end
    join
    model_frame(0, 8'h05, 1'b0, 1'b0);
    check_state(0, "t1");
    pop(0, "t1.pop");

    // 2: stream of bytes read back in order.
    frame(0, 8'h05, 1'b0, 1'b0, "t2");
    frame(0, 8'h06, 1'b0, 1'b0, "t2");
    frame(0, 8'h07, 1'b0, 1'b0, "t2");
    frame(0, 8'h0f, 1'b0, 1'b0, "t2");
    for (int i = 0; i < 4; i++) pop(0, "t2.pop");

    // 3: overrun after five unread frames, then clear.
    for (int i = 1; i <= 5; i++) frame(0, 8'(i), 1'b0, 1'b0, "t3");
    clear_err(0);

    // Full FIFO, pop lands on the push edge: both accepted, no overrun.
    fork
      send_frame(0, 8'h66, 1'b0, 1'b0);
      begin
        wait_clk(push_off(0) - 1);
        rd_v[0] = 1'b1;
        wait_clk(1);
        rd_v[0] = 1'b0;
      end
    join
    void'(mq[0].pop_front());
    model_frame(0, 8'h66, 1'b0, 1'b0);
    check_state(0, "full_push_pop");
    for (int i = 0; i < 4; i++) pop(0, "t3.drain");

    // Empty FIFO, pop lands on the push edge: push only.
    fork
      send_frame(0, 8'h77, 1'b0, 1'b0);
      begin
        wait_clk(push_off(0) - 1);
        rd_v[0] = 1'b1;
        wait_clk(1);
        rd_v[0] = 1'b0;
      end
    join
    model_frame(0, 8'h77, 1'b0, 1'b0);
    check_state(0, "empty_push_pop");
    pop(0, "t3.last");
    pop(0, "pop_when_empty");

    // 4: even parity, wrong then right; odd parity good frame.
    frame(1, 8'hAA, 1'b1, 1'b0, "t4.bad");
    frame(1, 8'hAA, 1'b0, 1'b0, "t4.good");
    frame(2, 8'hAA, 1'b0, 1'b0, "t4.odd");
    frame(2, 8'h3B, 1'b1, 1'b0, "t4.oddbad");

    // 5: glitch on the start bit, then a break.
    rx_v[0] = 1'b0;
    wait_clk(2);
    rx_v[0] = 1'b1;
    wait_clk(15 * TIMER);
    check_state(0, "t5.glitch");
    frame(0, 8'h81, 1'b0, 1'b1, "t5.break");
    clear_err(0);

    // 6: reset during data bit 3 of a frame.
    frame(0, 8'h11, 1'b0, 1'b0, "t6.pre");
    rb = 8'h3C;
    line_bit(0, 1'b0, TIMER);
    for (int i = 0; i < 3; i++) line_bit(0, rb[i], TIMER);
    line_bit(0, rb[3], 3);
    reset = 1'b1;
    for (int s = 0; s < NI; s++) rx_v[s] = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    model_reset();
    for (int s = 0; s < NI; s++) check_state(s, "t6.reset");
    wait_clk(2 * TIMER);
    d5a = 8'h5A;
    frame(0, d5a, 1'b0, 1'b0, "t6.after");
    pop(0, "t6.pop");

    // Randomized traffic across all three parity modes.
    for (int it = 0; it < 30; it++) begin
      sel  = $urandom_range(NI - 1);
      kind = $urandom_range(9);
      rb   = 8'($urandom);
      if (kind == 0) frame(sel, rb, 1'b0, 1'b1, "rnd.brk");
      else if (kind <= 2 && sel != 0) frame(sel, rb, 1'b1, 1'b0, "rnd.par");
      else frame(sel, rb, 1'b0, 1'b0, "rnd.good");
      if ($urandom_range(2) == 0) pop(sel, "rnd.pop");
      if ($urandom_range(5) == 0) clear_err(sel);
    end
    for (int s = 0; s < NI; s++) begin
      while (mq[s].size() > 0) pop(s, "final.drain");
      check_state(s, "final");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
